// File: rtl/fifo_rd_unloader_if.sv
// rtl/fifo_rd_unloader_if.sv - FIFO read port and output word stream bundle for fifo_rd_unloader
interface fifo_rd_unloader_if #(
    parameter int WIDTH = 66,
    parameter int PTR   = 4
);
    logic             fifo_rden;
    logic [WIDTH-1:0] fifo_dataout;
    logic             fifo_rdempty;
    logic [PTR:0]     fifo_rdusedw;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-3:0] out_data;
    logic             out_sop;
    logic             out_eop;

    // Unloader side: drives the FIFO read request and the output stream.
    // The fill level is carried for status observers only; the unloader never looks at it.
    modport master (
        output fifo_rden,
        input  fifo_dataout,
        input  fifo_rdempty,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_sop,
        output out_eop
    );

    // Environment side: the FIFO read port plus the downstream consumer.
    modport slave (
        input  fifo_rden,
        output fifo_dataout,
        output fifo_rdempty,
        output fifo_rdusedw,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_sop,
        input  out_eop
    );
endinterface

// File: rtl/fifo_rd_unloader.sv
// rtl/fifo_rd_unloader.sv - pops the clock-crossing FIFO into a 2-entry buffer and streams SOP/EOP framed words
module fifo_rd_unloader #(
    parameter int WIDTH = 66,
    parameter int PTR   = 4
) (
    input  logic                clk,
    input  logic                reset_,
    input  logic                enable,
    fifo_rd_unloader_if.master  bus,
    output logic [15:0]         pkt_cnt,
    output logic                framing_err
);
    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] buf_mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       buf_cnt;
    logic             inflight;
    logic [15:0]      pkt_cnt_q;
    logic             framing_err_q;
    logic             err_set;
    logic             pop;
    logic [2:0]       occ_nx;
    logic             rden;
    logic [WIDTH-1:0] head;
    logic             cap_sop;
    logic             cap_eop;

    assign head          = buf_mem[rd_ptr];
    assign bus.out_valid = (buf_cnt != 2'd0);
    // Fields read as zero whenever the buffer is empty, so reset clears them without touching storage.
    assign bus.out_data  = bus.out_valid ? head[WIDTH-3:0] : '0;
    assign bus.out_sop   = bus.out_valid & head[WIDTH-1];
    assign bus.out_eop   = bus.out_valid & head[WIDTH-2];

    assign pop = bus.out_valid & bus.out_ready;

    // Occupancy one edge from now: buffered plus the word already on its way, less the one leaving.
    // Never exceeds 2 because a read is only issued while this is at most 1.
    assign occ_nx = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};

    assign rden          = reset_ & enable & ~bus.fifo_rdempty & (occ_nx < 3'd2);
    assign bus.fifo_rden = rden;

    assign cap_sop = bus.fifo_dataout[WIDTH-1];
    assign cap_eop = bus.fifo_dataout[WIDTH-2];

    assign pkt_cnt     = pkt_cnt_q;
    assign framing_err = framing_err_q;

    // Buffer bookkeeping: track the in-flight read and move head/tail pointers.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            inflight <= rden;
            buf_cnt  <= occ_nx[1:0];
            if (inflight) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Buffer storage: capture the FIFO read data one cycle after the request.
    always_ff @(posedge clk) begin
        if (inflight) begin
            buf_mem[wr_ptr] <= bus.fifo_dataout;
        end
    end

    // Framing state register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Framing next state, judged on each word as it is captured; bad words are still forwarded.
    always_comb begin
        state_nx = state;
        err_set  = 1'b0;
        if (inflight) begin
            case (state)
                IDLE: begin
                    if (!cap_sop) begin
                        err_set = 1'b1;
                    end else if (!cap_eop) begin
                        state_nx = IN_PKT;
                    end
                end
                IN_PKT: begin
                    if (cap_sop) begin
                        err_set  = 1'b1;
                        state_nx = cap_eop ? IDLE : IN_PKT;
                    end else if (cap_eop) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Sticky framing error; only reset clears it.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            framing_err_q <= 1'b0;
        end else if (err_set) begin
            framing_err_q <= 1'b1;
        end
    end

    // Delivered-packet counter, bumped when the last word of a packet leaves; wraps naturally.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pkt_cnt_q <= 16'd0;
        end else begin
            pkt_cnt_q <= pkt_cnt_q + {15'd0, pop & bus.out_eop};
        end
    end
endmodule
